// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: sends a latched pattern MSB-first, repeated R times with G filler bits between frames.
// Define SEQ_GEN_PRBS_EN to fill the gaps from a 7-bit LFSR (x^7+x^6+1) instead of zeros.
module seq_pattern_gen #(
    parameter int PATTERN_W = 4,
    parameter int RPT_W     = 4,
    parameter int GAP_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 enable,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [RPT_W-1:0]     repeat_cnt,
    input  logic [GAP_W-1:0]     gap_len,
    output logic                 x,
    output logic                 x_valid,
    output logic                 frame_start,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = $clog2(PATTERN_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PATTERN_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t               state, state_nxt;
    logic [PATTERN_W-1:0] pat_q, pat_nxt;
    logic [GAP_W-1:0]     gap_q, gap_nxt;
    logic [RPT_W-1:0]     frm_q, frm_nxt;    // frames still to send after the current one
    logic [IDX_W-1:0]     idx_q, idx_nxt;    // index of the pattern bit currently on the line
    logic [GAP_W-1:0]     gcnt_q, gcnt_nxt;  // gap bits still to send after the current one
    logic                 step;
    logic                 gap_bit;
    logic                 x_nxt, xv_nxt, fs_nxt, busy_nxt, done_nxt;

`ifdef SEQ_GEN_PRBS_EN
    logic [6:0] lfsr_q;
    logic       lfsr_step;

    assign lfsr_step = step && (state_nxt == GAP);
    assign gap_bit   = lfsr_q[6];

    // Free-running across bursts; only rst reseeds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr_q <= 7'h7F;
        else if (lfsr_step)
            lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end
`else
    assign gap_bit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pat_q  <= '0;
            gap_q  <= '0;
            frm_q  <= '0;
            idx_q  <= '0;
            gcnt_q <= '0;
        end else begin
            state  <= state_nxt;
            pat_q  <= pat_nxt;
            gap_q  <= gap_nxt;
            frm_q  <= frm_nxt;
            idx_q  <= idx_nxt;
            gcnt_q <= gcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pat_nxt   = pat_q;
        gap_nxt   = gap_q;
        frm_nxt   = frm_q;
        idx_nxt   = idx_q;
        gcnt_nxt  = gcnt_q;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    pat_nxt   = pattern;
                    gap_nxt   = gap_len;
                    frm_nxt   = repeat_cnt - RPT_W'(1);
                    idx_nxt   = IDX_MSB;
                    state_nxt = (repeat_cnt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: if (enable) begin
                if (idx_q != '0) begin
                    idx_nxt = idx_q - IDX_W'(1);
                end else if (frm_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    frm_nxt = frm_q - RPT_W'(1);
                    if (gap_q != '0) begin
                        state_nxt = GAP;
                        gcnt_nxt  = gap_q - GAP_W'(1);
                    end else begin
                        idx_nxt = IDX_MSB;
                    end
                end
            end
            GAP: if (enable) begin
                if (gcnt_q != '0) begin
                    gcnt_nxt = gcnt_q - GAP_W'(1);
                end else begin
                    state_nxt = SHIFT;
                    idx_nxt   = IDX_MSB;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered; a frozen cycle holds x.
    assign step = (state == IDLE || state == DONE) ? 1'b1 : enable;

    always_comb begin
        x_nxt    = 1'b0;
        xv_nxt   = 1'b0;
        fs_nxt   = 1'b0;
        busy_nxt = (state_nxt == SHIFT) || (state_nxt == GAP);
        done_nxt = (state_nxt == DONE);
        case (state_nxt)
            SHIFT: begin
                if (step) begin
                    x_nxt  = pat_nxt[idx_nxt];
                    xv_nxt = 1'b1;
                    fs_nxt = (idx_nxt == IDX_MSB);
                end else begin
                    x_nxt = x;
                end
            end
            GAP: begin
                if (step) begin
                    x_nxt  = gap_bit;
                    xv_nxt = 1'b1;
                end else begin
                    x_nxt = x;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= 1'b0;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            x           <= x_nxt;
            x_valid     <= xv_nxt;
            frame_start <= fs_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed and random bursts checked against a bit-stream reference model.
// Build with SEQ_GEN_PRBS_EN defined to exercise the LFSR gap fill.
module tb_seq_pattern_gen;

    localparam int PW = 4;
    localparam int RW = 4;
    localparam int GW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          enable;
    logic [PW-1:0] pattern;
    logic [RW-1:0] repeat_cnt;
    logic [GW-1:0] gap_len;
    logic          x, x_valid, frame_start, busy, done;

    int checks = 0;
    int errors = 0;

    seq_pattern_gen #(.PATTERN_W(PW), .RPT_W(RW), .GAP_W(GW)) dut (
        .clk(clk), .rst(rst), .start(start), .enable(enable),
        .pattern(pattern), .repeat_cnt(repeat_cnt), .gap_len(gap_len),
        .x(x), .x_valid(x_valid), .frame_start(frame_start),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a burst is a queue of line symbols built from the burst rules.
    typedef struct packed {
        logic bitv;
        logic fs;
        logic is_gap;
    } item_t;

    item_t q[$];
    logic  m_active;
    logic  m_x, m_xv, m_fs, m_busy, m_done;
    logic  prbs [0:133];
    int    prbs_pos;

    function automatic logic next_gap_bit();
        logic b;
`ifdef SEQ_GEN_PRBS_EN
        b = prbs[prbs_pos % 127];
`else
        b = 1'b0;
`endif
        prbs_pos++;
        return b;
    endfunction

    function automatic void build(input logic [PW-1:0] p, input int r, input int g);
        q.delete();
        for (int f = 0; f < r; f++) begin
            for (int b = PW - 1; b >= 0; b--)
                q.push_back({p[b], (b == PW - 1), 1'b0});
            if (f < r - 1)
                for (int k = 0; k < g; k++)
                    q.push_back(3'b001);
        end
    endfunction

    function automatic void pop_item();
        item_t it;
        it     = q.pop_front();
        m_x    = it.is_gap ? next_gap_bit() : it.bitv;
        m_xv   = 1'b1;
        m_fs   = it.fs;
        m_busy = 1'b1;
        m_done = 1'b0;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_active = 1'b0;
        m_x = 1'b0; m_xv = 1'b0; m_fs = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        prbs_pos = 0;
    endfunction

    function automatic void model_edge();
        if (!m_active) begin
            m_x = 1'b0; m_xv = 1'b0; m_fs = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            if (start) begin
                build(pattern, int'(repeat_cnt), int'(gap_len));
                if (q.size() == 0) begin
                    m_done = 1'b1;
                end else begin
                    pop_item();
                    m_active = 1'b1;
                end
            end
        end else if (enable) begin
            if (q.size() == 0) begin
                m_active = 1'b0;
                m_x = 1'b0; m_xv = 1'b0; m_fs = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                pop_item();
            end
        end else begin
            m_xv = 1'b0;
            m_fs = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("x", x, m_x);
        chk("x_valid", x_valid, m_xv);
        chk("frame_start", frame_start, m_fs);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
    endtask

    function automatic logic pick_enable(input int en_pct);
        return (en_pct >= 100) ? 1'b1 : ($urandom_range(99) < en_pct);
    endfunction

    // One burst from start edge to the done pulse; also checks the valid-bit count.
    task automatic run_burst(input logic [PW-1:0] p, input int r, input int g,
                             input int en_pct, input bit poke, input int freeze_at);
        int n;
        bit seen;
        n          = 0;
        pattern    = p;
        repeat_cnt = r[RW-1:0];
        gap_len    = g[GW-1:0];
        start      = 1'b1;
        enable     = pick_enable(en_pct);
        cyc();
        start = 1'b0;
        n += int'(x_valid);
        seen = done;
        for (int k = 1; k < 600 && !seen; k++) begin
            enable = pick_enable(en_pct);
            if (k == freeze_at || k == freeze_at + 1)
                enable = 1'b0;
            if (poke) begin
                start      = ($urandom_range(3) == 0);
                pattern    = PW'($urandom);
                repeat_cnt = RW'($urandom);
                gap_len    = GW'($urandom);
            end
            cyc();
            n += int'(x_valid);
            seen = done;
        end
        start = 1'b0;
        chk_int("done_seen", int'(seen), 1);
        chk_int("burst_len", n, r * PW + ((r > 0) ? (r - 1) * g : 0));
    endtask

    initial begin
        for (int k = 0; k < 7; k++)
            prbs[k] = 1'b1;
        for (int k = 7; k < 134; k++)
            prbs[k] = prbs[k - 7] ^ prbs[k - 6];

        rst = 1'b1; start = 1'b0; enable = 1'b0;
        pattern = '0; repeat_cnt = '0; gap_len = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_x", x, 1'b0);
        chk("reset_x_valid", x_valid, 1'b0);
        chk("reset_frame_start", frame_start, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) cyc();

        // Single frame, back-to-back frames, gapped frames with ignored start pokes.
        run_burst(4'b1011, 1, 0, 100, 1'b0, -1);
        cyc();
        run_burst(4'b1011, 3, 0, 100, 1'b0, -1);
        cyc();
        run_burst(4'b1011, 2, 2, 100, 1'b1, -1);
        cyc();
        // Two frozen edges in the middle of a frame.
        run_burst(4'b1011, 1, 0, 100, 1'b0, 2);
        enable = 1'b0;
        cyc();
        // Zero repeats, with enable low to show it is ignored while idle.
        run_burst(4'b1011, 0, 3, 0, 1'b0, -1);
        enable = 1'b1;
        cyc();

        // Asynchronous reset in the middle of a burst.
        pattern = 4'b1011; repeat_cnt = 4'd3; gap_len = 3'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (2) cyc();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_x", x, 1'b0);
        chk("rst_mid_x_valid", x_valid, 1'b0);
        chk("rst_mid_frame_start", frame_start, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        #2;
        rst = 1'b0;
        run_burst(4'b1011, 1, 0, 100, 1'b0, -1);
        cyc();

        // Gap fill, then burst restarted directly from the done cycle.
        run_burst(4'b1011, 2, 3, 100, 1'b0, -1);
        run_burst(4'b0110, 2, 1, 100, 1'b0, -1);
        // Largest repeat count and gap length.
        run_burst(4'b1001, 15, 7, 100, 1'b0, -1);
        cyc();

        for (int i = 0; i < 25; i++) begin
            run_burst(PW'($urandom), $urandom_range(0, 6), $urandom_range(0, 7),
                      $urandom_range(50, 100), ($urandom_range(1) == 1), -1);
            if ($urandom_range(1) == 1) begin
                enable = $urandom_range(1) == 1;
                cyc();
            end
        end
        run_burst(PW'($urandom), 15, 7, 70, 1'b1, -1);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
